intadd_wb_buffer: RTL and testbench

- Writeback stage directly downstream of the intadd SIMD integer adder.
- Captures intadd results (one 128-bit result in 32-bit mode, two 128-bit results dst_reg0/dst_reg1 in 4+8-bit mode) together with destination register indices.
- Buffers the results in a small FIFO and serialises them onto the single vector register-file write port, applying backpressure to the issue side when full.

---
 rtl/intadd_wb_buffer.sv | 114 +++++++++++
 tb/tb_intadd_wb_buffer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intadd_wb_buffer.sv
// Writeback buffer behind the intadd SIMD adder: queues one- or two-result entries
// and serialises them onto the single vector register-file write port.
module intadd_wb_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_dual,
  input  logic [ADDR_W-1:0]            in_addr0,
  input  logic [ADDR_W-1:0]            in_addr1,
  input  logic [DATA_W-1:0]            in_data0,
  input  logic [DATA_W-1:0]            in_data1,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         wb_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err,
  input  logic                         clr_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              dual;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head;
  entry_t             entry_in;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               half_q, half_d;
  logic               ovf_q, ovf_d;

  logic               push;
  logic               pop;
  logic               beat;

  assign entry_in = '{dual: in_dual, addr0: in_addr0, addr1: in_addr1,
                      data0: in_data0, data1: in_data1};
  assign head     = mem_q[rd_ptr_q];

  // Handshake and output mux are functions of registered state only.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign wb_last  = wb_valid & (~head.dual | half_q);
  assign wb_addr  = !wb_valid ? '0 : (half_q ? head.addr1 : head.addr0);
  assign wb_data  = !wb_valid ? '0 : (half_q ? head.data1 : head.data0);
  assign count    = count_q;
  assign ovf_err  = ovf_q;

  assign push = in_valid & in_ready;
  assign beat = wb_valid & wb_ready;
  assign pop  = beat & wb_last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A non-final beat only advances to the second half of a dual entry.
    if (beat) half_d = ~wb_last;

    // New overflow takes priority over a same-cycle clear.
    if (in_valid && !in_ready) ovf_d = 1'b1;
    else if (clr_err)          ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

endmodule

// File: tb/tb_intadd_wb_buffer.sv
// Self-checking bench for intadd_wb_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_intadd_wb_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_dual;
  logic [ADDR_W-1:0] in_addr0;
  logic [ADDR_W-1:0] in_addr1;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_last;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;
  logic              clr_err;

  int checks;
  int errors;

  intadd_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dual(in_dual),
    .in_addr0(in_addr0), .in_addr1(in_addr1),
    .in_data0(in_data0), .in_data1(in_data1),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_last(wb_last), .count(count),
    .ovf_err(ovf_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending results and how many beats of the head were sent.
  typedef struct {
    bit                dual;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } ent_t;

  ent_t m_q[$];
  int   m_beats_sent;
  bit   m_ovf;

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit exp_valid();
    return m_q.size() != 0;
  endfunction

  function automatic bit exp_last();
    if (m_q.size() == 0) return 1'b0;
    return !m_q[0].dual || (m_beats_sent == 1);
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr();
    if (m_q.size() == 0) return '0;
    return (m_beats_sent == 1) ? m_q[0].a1 : m_q[0].a0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    if (m_q.size() == 0) return '0;
    return (m_beats_sent == 1) ? m_q[0].d1 : m_q[0].d0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_beats_sent = 0;
    m_ovf        = 1'b0;
  endtask

  // One clock: the model consumes the driven inputs at the edge, then we move to the falling edge.
  task automatic tick();
    bit   full;
    bit   was_valid;
    ent_t e;
    @(posedge clk);
    full      = (m_q.size() == DEPTH);
    was_valid = (m_q.size() != 0);
    if (was_valid && wb_ready) begin
      if (exp_last()) begin
        void'(m_q.pop_front());
        m_beats_sent = 0;
      end else begin
        m_beats_sent = 1;
      end
    end
    if (in_valid && !full) begin
      e.dual = in_dual; e.a0 = in_addr0; e.a1 = in_addr1;
      e.d0 = in_data0;  e.d1 = in_data1;
      m_q.push_back(e);
    end
    if (in_valid && full) m_ovf = 1'b1;
    else if (clr_err)     m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_dual = 1'b0; clr_err = 1'b0;
    in_addr0 = '0; in_addr1 = '0; in_data0 = '0; in_data1 = '0;
  endtask

  task automatic drain();
    idle_inputs();
    wb_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d ovf=%b, want 0 1 0 0",
               wb_valid, in_ready, count, ovf_err);
    end
    checks++;
    if (wb_addr !== '0 || wb_data !== '0 || wb_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d data=%h last=%b, want 0 0 0", wb_addr, wb_data, wb_last);
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    wb_ready = 1'b1;
    in_valid = 1'b1; in_dual = 1'b0; in_addr0 = 5'd3; in_data0 = d;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: got wb_valid=%b want 0", wb_valid);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== d || wb_last !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_beat: got v=%b a=%0d d=%h l=%b c=%0d, want 1 3 %h 1 1",
               wb_valid, wb_addr, wb_data, wb_last, count, d);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: got v=%b c=%0d, want 0 0", wb_valid, count);
    end
  endtask

  task automatic test_dual();
    wb_ready = 1'b1;
    in_valid = 1'b1; in_dual = 1'b1; in_addr0 = 5'd4; in_addr1 = 5'd9;
    in_data0 = {16{8'hAA}}; in_data1 = {16{8'h55}};
    tick();
    idle_inputs();
    checks++;
    if (wb_addr !== 5'd4 || wb_data !== {16{8'hAA}} || wb_last !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL dual_beat0: got a=%0d d=%h l=%b c=%0d, want 4 aa.. 0 1", wb_addr, wb_data, wb_last, count);
    end
    tick();
    checks++;
    if (wb_addr !== 5'd9 || wb_data !== {16{8'h55}} || wb_last !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL dual_beat1: got a=%0d d=%h l=%b c=%0d, want 9 55.. 1 1", wb_addr, wb_data, wb_last, count);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL dual_pop: got v=%b c=%0d, want 0 0", wb_valid, count);
    end
  endtask

  task automatic test_fill_overflow();
    logic [DATA_W-1:0] d [DEPTH];
    wb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d[i] = rand128();
      in_valid = 1'b1; in_dual = 1'b0; in_addr0 = ADDR_W'(10 + i); in_data0 = d[i];
      tick();
      checks++;
      if (count !== CNT_W'(i + 1)) begin
        errors++;
        $display("FAIL fill_count: got %0d want %0d", count, i + 1);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got in_ready=%b want 0", in_ready);
    end
    in_addr0 = 5'd31; in_data0 = rand128();
    tick();
    idle_inputs();
    checks++;
    if (ovf_err !== 1'b1 || count !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: got ovf=%b c=%0d, want 1 %0d", ovf_err, count, DEPTH);
    end
    wb_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== ADDR_W'(10 + i) || wb_data !== d[i]) begin
        errors++;
        $display("FAIL drain_order: got v=%b a=%0d d=%h want 1 %0d %h", wb_valid, wb_addr, wb_data, 10 + i, d[i]);
      end
      tick();
    end
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: got v=%b c=%0d ovf=%b want 0 0 1", wb_valid, count, ovf_err);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: got ovf=%b want 0", ovf_err);
    end
  endtask

  task automatic test_stall_dual();
    logic [DATA_W-1:0] d1;
    d1 = rand128();
    wb_ready = 1'b1;
    in_valid = 1'b1; in_dual = 1'b1; in_addr0 = 5'd7; in_addr1 = 5'd12;
    in_data0 = rand128(); in_data1 = d1;
    tick();
    idle_inputs();
    tick();
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_addr !== 5'd12 || wb_data !== d1 || wb_last !== 1'b1 || count !== 3'd1) begin
        errors++;
        $display("FAIL stall_hold: got a=%0d d=%h l=%b c=%0d want 12 %h 1 1", wb_addr, wb_data, wb_last, count, d1);
      end
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL stall_release: got v=%b c=%0d want 0 0", wb_valid, count);
    end
  endtask

  task automatic test_push_pop();
    wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_dual = 1'b0; in_addr0 = ADDR_W'(i + 1); in_data0 = rand128();
      tick();
    end
    wb_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      in_addr0 = ADDR_W'(i + 1); in_data0 = rand128();
      checks++;
      if (wb_addr !== exp_addr() || wb_data !== exp_data() || wb_addr !== ADDR_W'(i - 1)) begin
        errors++;
        $display("FAIL pushpop_order: got a=%0d want %0d", wb_addr, i - 1);
      end
      tick();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL pushpop_count: got %0d want 2", count);
      end
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wb_addr !== ADDR_W'(7 + i) || wb_data !== exp_data()) begin
        errors++;
        $display("FAIL pushpop_tail: got a=%0d want %0d", wb_addr, 7 + i);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b1;
    in_valid = 1'b1; in_dual = 1'b1; in_addr0 = 5'd20; in_addr1 = 5'd21;
    in_data0 = rand128(); in_data1 = rand128();
    tick();
    idle_inputs();
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || wb_addr !== '0 || wb_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b c=%0d r=%b a=%0d l=%b want 0 0 1 0 0",
               wb_valid, count, in_ready, wb_addr, wb_last);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_dual = 1'b1; in_addr0 = 5'd2; in_addr1 = 5'd5;
    in_data0 = rand128(); in_data1 = rand128();
    tick();
    idle_inputs();
    checks++;
    if (wb_addr !== 5'd2 || wb_last !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL reset_half: got a=%0d l=%b c=%0d want 2 0 1", wb_addr, wb_last, count);
    end
    drain();
  endtask

  task automatic test_clr_vs_ovf();
    wb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_dual = 1'b0; in_addr0 = ADDR_W'(i); in_data0 = rand128();
      tick();
    end
    clr_err = 1'b1;
    tick();
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got ovf=%b want 1", ovf_err);
    end
    in_valid = 1'b0;
    tick();
    clr_err = 1'b0;
    checks++;
    if (ovf_err !== 1'b0 || count !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL clr_after: got ovf=%b c=%0d want 0 %0d", ovf_err, count, DEPTH);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_dual  = $urandom_range(0, 1) == 1;
      in_addr0 = ADDR_W'($urandom());
      in_addr1 = ADDR_W'($urandom());
      in_data0 = rand128();
      in_data1 = rand128();
      wb_ready = ($urandom_range(0, 99) < 55);
      clr_err  = ($urandom_range(0, 99) < 5);
      tick();
      checks++;
      if (wb_valid !== exp_valid() || wb_last !== exp_last() || wb_addr !== exp_addr() ||
          wb_data !== exp_data() || count !== CNT_W'(m_q.size()) ||
          in_ready !== (m_q.size() != DEPTH) || ovf_err !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b l=%b a=%0d c=%0d r=%b o=%b d=%h want v=%b l=%b a=%0d c=%0d o=%b d=%h",
                 n, wb_valid, wb_last, wb_addr, count, in_ready, ovf_err, wb_data,
                 exp_valid(), exp_last(), exp_addr(), m_q.size(), m_ovf, exp_data());
      end
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    wb_ready = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_dual();
    test_fill_overflow();
    test_stall_dual();
    test_push_pop();
    test_async_reset();
    test_clr_vs_ovf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
